// File: rtl/weight_load_sched_if.sv
// weight_load_sched_if: control, weight ROM read and kernel bank write signals of the weight load scheduler
interface weight_load_sched_if #(
  parameter int ADDR_W       = 10,
  parameter int KERNEL_WIDTH = 72
);
  logic                    i_start, i_release, o_busy, o_err, o_rom_en, o_wr_en, o_ready;
  logic [ADDR_W-1:0]       i_base_addr, o_rom_addr;
  logic [3:0]              i_num_kernels, o_wr_slot;
  logic [KERNEL_WIDTH-1:0] i_rom_data, o_wr_data;
  modport master (
    input  i_start, i_base_addr, i_num_kernels, i_rom_data, i_release,
    output o_busy, o_err, o_rom_en, o_rom_addr, o_wr_en, o_wr_slot, o_wr_data, o_ready
  );
  modport slave (
    output i_start, i_base_addr, i_num_kernels, i_rom_data, i_release,
    input  o_busy, o_err, o_rom_en, o_rom_addr, o_wr_en, o_wr_slot, o_wr_data, o_ready
  );
endinterface

// File: rtl/weight_load_sched.sv
// weight_load_sched: loads N kernel words from the weight ROM into bank slots 0..N-1 and holds the bank until released.
// Define WLS_ZERO_FILL_EN to zero-fill the unused slots N..NUM_SLOTS-1 before signalling ready.
module weight_load_sched #(
  parameter int KERNEL_WIDTH = 72,
  parameter int NUM_SLOTS    = 12,
  parameter int ADDR_W       = 10,
  parameter int ROM_LAT      = 1
) (
  input logic clk,
  input logic rst,
  weight_load_sched_if.master bus
);
`ifdef WLS_ZERO_FILL_EN
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, ZFILL, READY} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, READY} state_t;
`endif
  localparam logic [3:0] SLOTS = 4'(NUM_SLOTS);
  localparam logic [3:0] LAST  = 4'(NUM_SLOTS - 1);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [3:0]          n_q, n_d, iss_q, iss_d, ret_q, ret_d;
  logic [ROM_LAT-1:0]  vld_q;
  logic                err_q, err_d, ret_vld, start_ok;
  assign ret_vld   = vld_q[ROM_LAT-1];
  assign start_ok  = bus.i_num_kernels != 4'd0 && bus.i_num_kernels <= SLOTS;
  assign bus.o_err   = err_q;
  assign bus.o_ready = state_q == READY;
  assign bus.o_busy  = !(state_q == IDLE || state_q == READY);
  // returns are written in arrival order; ret_q doubles as the slot index
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    n_d            = n_q;
    iss_d          = iss_q;
    ret_d          = ret_vld ? ret_q + 4'd1 : ret_q;
    err_d          = 1'b0;
    bus.o_rom_en   = 1'b0;
    bus.o_rom_addr = '0;
    bus.o_wr_en    = ret_vld;
    bus.o_wr_slot  = ret_vld ? ret_q : '0;
    bus.o_wr_data  = ret_vld ? bus.i_rom_data : '0;
    case (state_q)
      IDLE: if (bus.i_start) begin
        err_d   = !start_ok;
        state_d = start_ok ? FETCH : IDLE;
        base_d  = start_ok ? bus.i_base_addr : base_q;
        n_d     = start_ok ? bus.i_num_kernels : n_q;
        iss_d   = '0;
        ret_d   = '0;
      end
      FETCH: begin
        bus.o_rom_en   = 1'b1;
        bus.o_rom_addr = base_q + ADDR_W'(iss_q);
        iss_d          = iss_q + 4'd1;
        state_d        = iss_q == n_q - 4'd1 ? DRAIN : FETCH;
      end
`ifdef WLS_ZERO_FILL_EN
      DRAIN: state_d = ret_d != n_q ? DRAIN : (n_q == SLOTS ? READY : ZFILL);
      ZFILL: begin
        bus.o_wr_en   = 1'b1;
        bus.o_wr_slot = ret_q;
        bus.o_wr_data = '0;
        ret_d         = ret_q + 4'd1;
        state_d       = ret_q == LAST ? READY : ZFILL;
      end
`else
      DRAIN: state_d = ret_d == n_q ? READY : DRAIN;
`endif
      READY: state_d = bus.i_release ? IDLE : READY;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      n_q     <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      vld_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      n_q     <= n_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      vld_q   <= ROM_LAT'({vld_q, bus.o_rom_en});
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_weight_load_sched.sv
// tb_weight_load_sched: scoreboard bench; stimulus queues expected ROM reads and bank writes, a negedge monitor checks them.
module tb_weight_load_sched;
  localparam int KW = 72;
  localparam int AW = 10;
  typedef struct {logic [3:0] slot; logic [KW-1:0] data; int cyc;} wr_t;
  typedef struct {logic [AW-1:0] addr; int cyc;} rd_t;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0;
  int errs = 0;
  int checks = 0;
  int rc;
  wr_t wq1[$], wq3[$];
  rd_t rq1[$], rq3[$];
  logic [KW-1:0] p1, p3a, p3b, p3c;
  weight_load_sched_if #(.ADDR_W(AW), .KERNEL_WIDTH(KW)) b1 ();
  weight_load_sched_if #(.ADDR_W(AW), .KERNEL_WIDTH(KW)) b3 ();
  weight_load_sched #(.ROM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1.master));
  weight_load_sched #(.ROM_LAT(3)) u3 (.clk(clk), .rst(rst), .bus(b3.master));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [KW-1:0] rom_f(input logic [AW-1:0] a);
    return {2'b10, {7{a}}} ^ 72'h5A_0123_4567_89AB_CDEF;
  endfunction
  always @(posedge clk) begin
    p1  <= rom_f(b1.o_rom_addr);
    p3a <= rom_f(b3.o_rom_addr);
    p3b <= p3a;
    p3c <= p3b;
  end
  assign b1.i_rom_data = p1;
  assign b3.i_rom_data = p3c;
  task automatic chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic unexpected(input string nm);
    checks++;
    errs++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask
  always @(negedge clk) begin
    rd_t r;
    wr_t w;
    if (b1.o_rom_en) begin
      if (rq1.size() == 0) unexpected("rd1");
      else begin
        r = rq1.pop_front();
        chk("rd1 addr", b1.o_rom_addr, r.addr);
        chk("rd1 cycle", cyc, r.cyc);
      end
    end
    if (b1.o_wr_en) begin
      if (wq1.size() == 0) unexpected("wr1");
      else begin
        w = wq1.pop_front();
        chk("wr1 slot", b1.o_wr_slot, w.slot);
        chk("wr1 data", b1.o_wr_data, w.data);
        chk("wr1 cycle", cyc, w.cyc);
      end
    end
    if (b3.o_rom_en) begin
      if (rq3.size() == 0) unexpected("rd3");
      else begin
        r = rq3.pop_front();
        chk("rd3 addr", b3.o_rom_addr, r.addr);
        chk("rd3 cycle", cyc, r.cyc);
      end
    end
    if (b3.o_wr_en) begin
      if (wq3.size() == 0) unexpected("wr3");
      else begin
        w = wq3.pop_front();
        chk("wr3 slot", b3.o_wr_slot, w.slot);
        chk("wr3 data", b3.o_wr_data, w.data);
        chk("wr3 cycle", cyc, w.cyc);
      end
    end
  end
  // d selects the DUT (1: ROM_LAT=1, 3: ROM_LAT=3); nr/nw bound how many reads/writes are expected
  task automatic start(input int d, input logic [AW-1:0] base, input logic [3:0] n,
                       input int nr, input int nw, output int rdy);
    int c0;
    rd_t r;
    wr_t w;
    @(negedge clk);
    c0 = cyc;
    if (d == 1) begin b1.i_start = 1; b1.i_base_addr = base; b1.i_num_kernels = n; end
    else        begin b3.i_start = 1; b3.i_base_addr = base; b3.i_num_kernels = n; end
    for (int k = 0; k < nr; k++) begin
      r = '{base + AW'(k), c0 + 1 + k};
      if (d == 1) rq1.push_back(r); else rq3.push_back(r);
    end
    for (int k = 0; k < nw; k++) begin
      w = '{4'(k), rom_f(base + AW'(k)), c0 + 1 + d + k};
      if (d == 1) wq1.push_back(w); else wq3.push_back(w);
    end
    rdy = c0 + int'(n) + d + 1;
`ifdef WLS_ZERO_FILL_EN
    if (nw == int'(n) && n != 0 && n <= 12) begin
      for (int s = int'(n); s < 12; s++) begin
        w = '{4'(s), '0, c0 + 1 + d + s};
        if (d == 1) wq1.push_back(w); else wq3.push_back(w);
      end
      rdy = c0 + 12 + d + 1;
    end
`endif
    @(negedge clk);
    b1.i_start = 0;
    b3.i_start = 0;
  endtask
  task automatic wait_ready(input int d, input int rdy);
    int t = 0;
    while (!(d == 1 ? b1.o_ready : b3.o_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ready first cycle", cyc, rdy);
    chk("busy low at ready", d == 1 ? b1.o_busy : b3.o_busy, 0);
    chk("writes drained", d == 1 ? wq1.size() : wq3.size(), 0);
  endtask
  task automatic release1;
    @(negedge clk);
    b1.i_release = 1;
    @(negedge clk);
    b1.i_release = 0;
    chk("ready cleared on release", {b1.o_ready, b1.o_busy}, 0);
  endtask
  task automatic all_zero(input string nm);
    chk(nm, {b1.o_rom_en, b1.o_rom_addr, b1.o_wr_en, b1.o_wr_slot, b1.o_ready, b1.o_busy, b1.o_err}, 0);
    chk({nm, " data"}, b1.o_wr_data, 0);
  endtask
  initial begin
    b1.i_start = 0; b1.i_release = 0; b1.i_base_addr = '0; b1.i_num_kernels = '0;
    b3.i_start = 0; b3.i_release = 0; b3.i_base_addr = '0; b3.i_num_kernels = '0;
    repeat (3) @(negedge clk);
    all_zero("reset outputs");
    rst = 0;
    start(1, 10'h100, 4'd12, 12, 12, rc);
    chk("busy in fetch", b1.o_busy, 1);
    wait_ready(1, rc);
    release1();
    start(1, 10'h3FE, 4'd4, 4, 4, rc);
    wait_ready(1, rc);
    release1();
    start(1, 10'h000, 4'd0, 0, 0, rc);
    chk("err on N=0", b1.o_err, 1);
    chk("idle after N=0", {b1.o_rom_en, b1.o_busy}, 0);
    @(negedge clk);
    chk("err one cycle", b1.o_err, 0);
    start(1, 10'h000, 4'd13, 0, 0, rc);
    chk("err on N=13", b1.o_err, 1);
    chk("idle after N=13", {b1.o_rom_en, b1.o_busy}, 0);
    @(negedge clk);
    chk("err one cycle", b1.o_err, 0);
    start(1, 10'h155, 4'd2, 2, 2, rc);
    wait_ready(1, rc);
    release1();
    start(1, 10'h200, 4'd12, 5, 4, rc);
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    all_zero("outputs after mid reset");
    repeat (5) @(negedge clk);
    chk("no pending reads", rq1.size(), 0);
    chk("no pending writes", wq1.size(), 0);
    start(1, 10'h050, 4'd3, 3, 3, rc);
    wait_ready(1, rc);
    @(negedge clk);
    b1.i_start = 1; b1.i_num_kernels = 4'd3;
    @(negedge clk);
    b1.i_start = 0;
    chk("start ignored in ready", {b1.o_ready, b1.o_busy, b1.o_err}, 3'b100);
    repeat (3) @(negedge clk);
    chk("ready held", b1.o_ready, 1);
    b1.i_start = 1; b1.i_release = 1;
    @(negedge clk);
    b1.i_start = 0; b1.i_release = 0;
    chk("release wins", {b1.o_ready, b1.o_busy, b1.o_err}, 0);
    repeat (4) @(negedge clk);
    chk("no load after dropped start", {b1.o_ready, b1.o_busy, b1.o_rom_en}, 0);
    start(3, 10'h010, 4'd5, 5, 5, rc);
    wait_ready(3, rc);
    repeat (2) @(negedge clk);
    chk("rd queues empty", rq1.size() + rq3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/weight_load_sched.md
Name: weight_load_sched

Overview:
- Sequences weight loading into the 12-slot kernel register bank that feeds the conv datapath.
- On a start command it reads N consecutive 72-bit kernel words (9 x 8-bit weights each) from the weight ROM and writes each into slot 0..N-1 of the bank.
- When all words are written it raises o_ready and holds the bank stable until the datapath releases it.

Parameters:
- KERNEL_WIDTH, 72, bits per kernel word (9 weights x 8 bits).
- NUM_SLOTS, 12, number of kernel slots in the bank.
- ADDR_W, 10, weight ROM address width.
- ROM_LAT, 1, ROM read latency in cycles (legal range 1..3).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle load request; sampled only in IDLE.
- i_base_addr  in  ADDR_W  first ROM address of the layer's kernels.
- i_num_kernels  in  4  kernel count N; legal range 1..NUM_SLOTS.
- o_busy  out  1  high in FETCH, DRAIN, ZFILL.
- o_err  out  1  one-cycle pulse when a start is rejected.
- o_rom_en  out  1  ROM read enable.
- o_rom_addr  out  ADDR_W  ROM read address.
- i_rom_data  in  KERNEL_WIDTH  ROM data, valid ROM_LAT cycles after o_rom_en.
- o_wr_en  out  1  bank slot write strobe.
- o_wr_slot  out  4  bank slot index.
- o_wr_data  out  KERNEL_WIDTH  bank write data.
- o_ready  out  1  bank fully loaded and stable.
- i_release  in  1  datapath finished with current weights.

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0. FSM goes to IDLE, counters clear, return-valid pipe clears.
- FSM states: IDLE, FETCH, DRAIN, ZFILL, READY.
- IDLE:
  - i_start with 1<=N<=NUM_SLOTS: latch base and N, go to FETCH.
  - i_start with N=0 or N>NUM_SLOTS: o_err=1 next cycle, stay in IDLE.
- FETCH:
  - Each cycle o_rom_en=1 and o_rom_addr=base+k, for k=0..N-1.
  - First issue is the cycle after i_start.
  - Address addition wraps modulo 2^ADDR_W.
  - After issuing k=N-1, go to DRAIN.
- Return path:
  - A ROM_LAT-deep valid shift register tracks issued reads.
  - When a valid exits the pipe, drive o_wr_en=1, o_wr_slot=return count, o_wr_data=i_rom_data.
  - Then increment the return count.
  - Writes therefore occur in order, slots 0..N-1, one per cycle, with no gaps.
- DRAIN: wait until the return count reaches N, then go to ZFILL (feature enabled) or READY.
- READY:
  - o_ready=1; no writes occur.
  - On i_release, o_ready=0 next cycle and the FSM goes to IDLE.
- Timing (start at cycle 0, feature disabled):
  - ROM reads in cycles 1..N.
  - Writes in cycles 1+ROM_LAT..N+ROM_LAT.
  - o_ready first high at cycle N+ROM_LAT+1.
- Boundary conditions:
  - i_start outside IDLE is ignored (no o_err).
  - i_start and i_release in the same cycle in READY: release wins; the start is dropped.
  - rst mid-operation: in-flight ROM returns are discarded (valid pipe cleared), so no write follows reset.
  - N=NUM_SLOTS uses slot indices 0..11; slot index never exceeds NUM_SLOTS-1.
- o_busy=1 exactly in FETCH, DRAIN and ZFILL.

Optional Feature:
- Macro: WLS_ZERO_FILL_EN.
- Defined:
  - After DRAIN, ZFILL writes zero to slots N..NUM_SLOTS-1, one per cycle.
  - Writes use o_wr_en=1 and o_wr_data=0; then go to READY.
  - If N=NUM_SLOTS, ZFILL is skipped.
  - o_ready is first high at cycle NUM_SLOTS+ROM_LAT+1.
- Undefined: no ZFILL state; unused slots keep their previous contents; DRAIN goes directly to READY.

Test Plan:
- ROM_LAT=1, base=0x100, N=12:
  - reads at addresses 0x100..0x10B in cycles 1..12;
  - writes to slots 0..11 in cycles 2..13 carrying ROM data;
  - o_ready=1 at cycle 14; o_busy low at 14.
- base=0x3FE, N=4, ADDR_W=10 -> o_rom_addr sequence 0x3FE, 0x3FF, 0x000, 0x001; slots 0..3 written.
- N=0, then N=13 -> o_err pulses once per start, no o_rom_en, FSM stays in IDLE; a following N=2 start loads normally.
- WLS_ZERO_FILL_EN defined, N=3 -> slots 0..2 get ROM data, slots 3..11 get 0 in consecutive cycles; o_ready at cycle 14 (ROM_LAT=1).
- rst asserted in cycle 5 of an N=12 load -> from the next cycle all outputs are 0 and no o_wr_en occurs; a new start loads slots from 0.
- In READY: i_start alone is ignored (o_ready stays 1); i_start+i_release together -> IDLE, no new load; ROM_LAT=3 run with N=5 gives o_ready at cycle 9.
